// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the scan select generator.
// Imported by the interface, the next-select search and the top level.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [NUM_CH-1:0] mask_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STEP = 2'd2;

endpackage

// File: rtl/scan_sel_gen_if.sv
// Control and decoder-facing signals of the scan select generator.
// The master drives the scan controls; the slave (the generator) drives the select outputs.
interface scan_sel_gen_if #(
    parameter int DIV_W = 16
);
    import scan_pkg::*;

    logic             i_en;
    logic             i_mode;
    logic             i_dir;
    logic             i_step;
    logic [DIV_W-1:0] i_div;
    mask_t            i_mask;
    logic             i_inv;
    sel_t             o_sel;
    logic             o_opt;
    logic             o_valid;
    logic             o_wrap;

    modport master (
        output i_en, i_mode, i_dir, i_step, i_div, i_mask, i_inv,
        input  o_sel, o_opt, o_valid, o_wrap
    );

    modport slave (
        input  i_en, i_mode, i_dir, i_step, i_div, i_mask, i_inv,
        output o_sel, o_opt, o_valid, o_wrap
    );

endinterface

// File: rtl/scan_next_sel.sv
// Cyclic search for the nearest enabled channel after sel in the requested direction.
// Purely combinational: reports the next channel, whether the 7/0 boundary was crossed, and an empty mask.
module scan_next_sel
    import scan_pkg::*;
(
    input  sel_t  sel,
    input  mask_t mask,
    input  logic  dir,
    output sel_t  next_sel,
    output logic  wrap,
    output logic  none
);

    int   pos;
    sel_t cand;

    // NOTE: every output and temporary gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        next_sel = sel;
        wrap     = 1'b0;
        none     = 1'b1;
        pos      = 0;
        cand     = '0;
        // Distance 8 comes back to sel itself, so a lone set bit reselects the current channel.
        for (int k = 1; k <= NUM_CH; k++) begin
            pos  = dir ? int'(sel) - k : int'(sel) + k;
            cand = SEL_W'(pos);
            if (none && mask[cand]) begin
                next_sel = cand;
                wrap     = (pos < 0) || (pos >= NUM_CH);
                none     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Channel select generator for a 3-to-8 decoder: automatic prescaled scan or manual single-step,
// ascending or descending, skipping channels cleared in the enable mask.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int   DIV_W       = 16,
    parameter logic INV_DEFAULT = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    scan_sel_gen_if.slave  bus
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic             step_q;
    logic             run_active;
    logic             tick;
    logic             step_evt;
    logic             advance;
    sel_t             sel_srch;
    sel_t             sel_nxt;
    logic             wrap_srch;
    logic             none_srch;

    scan_next_sel u_next_sel (
        .sel      (bus.o_sel),
        .mask     (bus.i_mask),
        .dir      (bus.i_dir),
        .next_sel (sel_srch),
        .wrap     (wrap_srch),
        .none     (none_srch)
    );

    always_comb begin
        state_nxt = state;
        if (!bus.i_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = bus.i_mode ? STEP : RUN;
                RUN:     if (bus.i_mode)  state_nxt = STEP;
                STEP:    if (!bus.i_mode) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A reload lowered below the running count restarts from 0 without a tick.
    assign run_active = (state == RUN) && bus.i_en;
    assign tick       = run_active && (cnt == bus.i_div);
    assign cnt_nxt    = (!run_active || cnt >= bus.i_div) ? '0 : cnt + 1'b1;

    // Step edges seen in RUN or on the cycle entering STEP are dropped because state is not yet STEP.
    assign step_evt = (state == STEP) && bus.i_en && bus.i_step && !step_q;
    assign advance  = (tick || step_evt) && !none_srch;
    assign sel_nxt  = advance ? sel_srch : bus.o_sel;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            step_q      <= 1'b0;
            bus.o_sel   <= '0;
            bus.o_valid <= 1'b0;
            bus.o_wrap  <= 1'b0;
            bus.o_opt   <= INV_DEFAULT;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            step_q      <= bus.i_step;
            bus.o_sel   <= sel_nxt;
            bus.o_wrap  <= advance && wrap_srch;
            // Valid follows the select it is registered with, so it lines up with o_sel.
            bus.o_valid <= bus.i_en && bus.i_mask[sel_nxt];
            if (state != IDLE) begin
                bus.o_opt <= bus.i_inv;
            end
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen: auto scan, descending skip, empty mask, step mode,
// async reset, reload change and enable drop, all against hand-computed sequences.
module tb_scan_sel_gen;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    int exp_sel_desc  [6] = '{0, 7, 2, 0, 7, 2};
    int exp_wrap_desc [6] = '{0, 1, 0, 0, 1, 0};
    int exp_sel_div   [10] = '{7, 7, 7, 0, 0, 0, 1, 1, 1, 2};
    int exp_wrap_div  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    scan_sel_gen_if #(.DIV_W(16)) bus ();

    scan_sel_gen #(
        .DIV_W       (16),
        .INV_DEFAULT (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; inputs change and outputs are sampled here.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.i_en   = 1'b0;
        bus.i_mode = 1'b0;
        bus.i_dir  = 1'b0;
        bus.i_step = 1'b0;
        bus.i_div  = 16'd3;
        bus.i_mask = 8'hFF;
        bus.i_inv  = 1'b0;

        cycle();
        cycle();
        check("rst_sel",   32'(bus.o_sel),   0);
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_wrap",  32'(bus.o_wrap),  0);
        check("rst_opt",   32'(bus.o_opt),   1);

        // Ascending scan, reload 3: one advance every 4 cycles, first one 4 cycles after entering RUN.
        rst_n    = 1'b1;
        bus.i_en = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            cycle();
            check($sformatf("asc_sel_%0d", c),   32'(bus.o_sel),   ((c - 1) / 4) % 8);
            check($sformatf("asc_wrap_%0d", c),  32'(bus.o_wrap),  32'(c == 33));
            check($sformatf("asc_valid_%0d", c), 32'(bus.o_valid), 1);
        end
        check("asc_opt", 32'(bus.o_opt), 0);

        // Reset mid-scan at o_sel=5, checked before the next clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel",   32'(bus.o_sel),   0);
        check("arst_opt",   32'(bus.o_opt),   1);
        check("arst_valid", 32'(bus.o_valid), 0);

        // Descending over mask 1000_0101 with a tick every cycle.
        bus.i_div  = 16'd0;
        bus.i_mask = 8'b1000_0101;
        bus.i_dir  = 1'b1;
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            check($sformatf("desc_sel_%0d", c),  32'(bus.o_sel),  exp_sel_desc[c]);
            check($sformatf("desc_wrap_%0d", c), 32'(bus.o_wrap), exp_wrap_desc[c]);
            if (c == 0) check("idle_opt_hold", 32'(bus.o_opt), 1);
        end

        // Empty mask: select frozen, valid low, no wrap; then a lone channel 4.
        bus.i_mask = 8'h00;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check($sformatf("empty_sel_%0d", c),   32'(bus.o_sel),   2);
            check($sformatf("empty_valid_%0d", c), 32'(bus.o_valid), 0);
            check($sformatf("empty_wrap_%0d", c),  32'(bus.o_wrap),  0);
        end
        bus.i_mask = 8'h10;
        cycle();
        check("lone_sel",   32'(bus.o_sel),   4);
        check("lone_valid", 32'(bus.o_valid), 1);
        check("lone_wrap",  32'(bus.o_wrap),  1);
        cycle();
        check("lone_resel_sel",  32'(bus.o_sel),  4);
        check("lone_resel_wrap", 32'(bus.o_wrap), 1);

        // Step mode: i_step rises on the transition cycle and is held, then three clean pulses.
        bus.i_div  = 16'd100;
        bus.i_mode = 1'b1;
        bus.i_mask = 8'hFF;
        bus.i_dir  = 1'b0;
        bus.i_step = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check($sformatf("held_sel_%0d", c), 32'(bus.o_sel), 4);
        end
        bus.i_step = 1'b0;
        cycle();
        check("step_low_sel", 32'(bus.o_sel), 4);
        for (int p = 0; p < 3; p++) begin
            bus.i_step = 1'b1;
            cycle();
            check($sformatf("pulse_sel_%0d", p),  32'(bus.o_sel),  5 + p);
            check($sformatf("pulse_wrap_%0d", p), 32'(bus.o_wrap), 0);
            bus.i_step = 1'b0;
            cycle();
            check($sformatf("pulse_hold1_%0d", p), 32'(bus.o_sel), 5 + p);
            cycle();
            check($sformatf("pulse_hold2_%0d", p), 32'(bus.o_sel), 5 + p);
        end

        // Back to RUN with reload 100; after 50 counts, lower the reload to 2.
        bus.i_mode = 1'b0;
        cycle();
        for (int c = 1; c <= 50; c++) begin
            cycle();
            check($sformatf("div100_sel_%0d", c), 32'(bus.o_sel), 7);
        end
        bus.i_div = 16'd2;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check($sformatf("div2_sel_%0d", c),  32'(bus.o_sel),  exp_sel_div[c]);
            check($sformatf("div2_wrap_%0d", c), 32'(bus.o_wrap), exp_wrap_div[c]);
        end

        // Enable drop: select holds, valid clears, polarity frozen while idle.
        bus.i_en = 1'b0;
        cycle();
        check("endrop_sel",   32'(bus.o_sel),   2);
        check("endrop_valid", 32'(bus.o_valid), 0);
        check("endrop_opt",   32'(bus.o_opt),   0);
        bus.i_inv = 1'b1;
        cycle();
        check("idle_opt_0", 32'(bus.o_opt), 0);
        cycle();
        check("idle_opt_1", 32'(bus.o_opt), 0);
        check("idle_sel",   32'(bus.o_sel), 2);
        bus.i_en = 1'b1;
        cycle();
        check("reen_opt",   32'(bus.o_opt),   0);
        check("reen_valid", 32'(bus.o_valid), 1);
        cycle();
        check("run_opt", 32'(bus.o_opt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 Parameter DIV_W, default 16: width of the prescaler reload value i_div.
REQ-002 Parameter INV_DEFAULT, default 1'b1: value loaded into o_opt at reset.
REQ-003 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_en  input  1  scan enable; low forces state IDLE.
REQ-006 i_mode  input  1  0 = automatic scan, 1 = manual single-step.
REQ-007 i_dir  input  1  0 = ascending channel order, 1 = descending.
REQ-008 i_step  input  1  manual step request, level input; acted on at its rising edge only.
REQ-009 i_div  input  DIV_W  prescaler reload; one advance every i_div+1 cycles in automatic mode.
REQ-010 i_mask  input  8  channel enable mask; bit n set = channel n may be selected.
REQ-011 i_inv  input  1  requested output polarity; sampled into o_opt.
REQ-012 o_sel  output  3  registered channel select for the downstream 3-to-8 decoder.
REQ-013 o_opt  output  1  registered polarity for the downstream decoder: 1 = active-low one-cold output.
REQ-014 o_valid  output  1  registered; high when o_sel names an enabled channel.
REQ-015 o_wrap  output  1  registered one-cycle pulse when o_sel wraps (7->0 ascending, 0->7 descending, across skipped channels).

Function
REQ-016 States: IDLE, RUN, STEP.
REQ-017 State transitions:
- Any state with i_en=0: go to IDLE.
- IDLE with i_en=1: go to RUN if i_mode=0, else STEP.
- RUN with i_mode=1: go to STEP.
- STEP with i_mode=0: go to RUN.
REQ-018 Prescaler counter: cleared in IDLE and STEP; in RUN it counts 0..i_div and produces tick when count==i_div, then reloads 0.
REQ-019 i_div=0 produces a tick every cycle in RUN.
REQ-020 If i_div is changed below the current count, the counter wraps to 0 on the next cycle without producing a tick.
REQ-021 An advance event is either a RUN tick or, in STEP, a rising edge of i_step (registered edge detect, one event per edge).
REQ-022 On an advance, o_sel on the next edge becomes the nearest set mask bit after o_sel in direction i_dir, searching cyclically.
REQ-023 The new o_sel is visible one cycle after the tick or detected edge.
REQ-024 When the advance search crosses the 7/0 boundary, o_wrap pulses high together with the o_sel update.
REQ-025 If exactly one mask bit is set, an advance reselects that channel, and o_wrap pulses only if the search crossed the boundary.
REQ-026 If i_mask==0: o_sel holds, o_valid=0, no advance and no o_wrap occur, and the prescaler keeps running.
REQ-027 o_valid = i_mask[o_sel], registered (one cycle delay).
REQ-028 Clearing the mask bit of the current o_sel does not force an immediate move; the channel is left on the next advance.
REQ-029 An i_step edge that arrives while in RUN, or during the transition cycle into STEP, is ignored.
REQ-030 o_opt samples i_inv every cycle except in IDLE, where it holds its value.
REQ-031 When i_en falls, o_sel holds its last value, o_valid is forced to 0, and the prescaler clears.

Reset
REQ-032 Reset values: state=IDLE, prescaler=0, o_sel=0, o_valid=0, o_wrap=0, o_opt=INV_DEFAULT, step edge register=0.
REQ-033 Reset asserted mid-scan clears all state asynchronously.
REQ-034 After release, the first advance occurs no earlier than i_div+1 cycles after entering RUN.

Structure
REQ-035 Package scan_pkg shall hold:
- the state encoding (IDLE=2'd0, RUN=2'd1, STEP=2'd2);
- constant NUM_CH=8;
- constant SEL_W=3.
REQ-036 Sub-module scan_next_sel shall be purely combinational: inputs current sel, mask, dir; outputs next sel, wrap flag, none-found flag.

Verification
REQ-037 Reset, then i_en=1, i_mode=0, i_div=3, i_mask=8'hFF, i_dir=0 -> o_sel steps 0,1,...,7,0 every 4 cycles, with o_wrap high for exactly 1 cycle on 7->0.
REQ-038 i_mask=8'b1000_0101, i_dir=1, i_div=0 -> o_sel sequence 0,7,2,0,7, with o_wrap on each 0->7.
REQ-039 i_mode=1, i_step held high 10 cycles then low, pulsed 3 times -> exactly 3 advances, none while held.
REQ-040 i_mask=0 during RUN -> o_valid=0 within 1 cycle and o_sel frozen; restoring i_mask=8'h10 -> next tick gives o_sel=4, o_valid=1.
REQ-041 i_rst_n asserted mid-scan at o_sel=5 -> o_sel=0 and o_opt=INV_DEFAULT immediately, without waiting for a clock edge.
REQ-042 i_div lowered from 100 to 2 while count=50 -> count wraps to 0 with no tick, then ticks every 3 cycles.
